// File: rtl/glip_mem_responder_if.sv
// GLIP FIFO channel pair between a backend (host side) and user logic.
// The slave modport is the user-logic endpoint; master is the backend side.
interface glip_mem_responder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] fifo_in_data;
  logic             fifo_in_valid;
  logic             fifo_in_ready;
  logic [WIDTH-1:0] fifo_out_data;
  logic             fifo_out_valid;
  logic             fifo_out_ready;

  modport slave (
    input  fifo_in_data,
    input  fifo_in_valid,
    output fifo_in_ready,
    output fifo_out_data,
    output fifo_out_valid,
    input  fifo_out_ready
  );

  modport master (
    output fifo_in_data,
    output fifo_in_valid,
    input  fifo_in_ready,
    input  fifo_out_data,
    input  fifo_out_valid,
    output fifo_out_ready
  );
endinterface

// File: rtl/glip_mem_responder.sv
// GLIP memory responder: a 256-word scratch memory driven by burst
// read/write request headers on the incoming channel. Writes are answered
// with an echo of the header, reads stream the addressed words back.
module glip_mem_responder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                  clk_logic,
  input  logic                  rst,
  glip_mem_responder_if.slave   glip,
  output logic                  busy,
  output logic [15:0]           req_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WACK  = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_addr;
  logic [6:0]       r_cnt;
  logic [15:0]      r_hdr;
  logic [15:0]      r_req_count;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_in_ready;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_out_data;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_last;
  logic             w_done;

  assign w_in_fire  = glip.fifo_in_valid & w_in_ready;
  assign w_out_fire = w_out_valid & glip.fifo_out_ready;
  assign w_last     = (r_cnt == 7'd0);
  // A transaction completes on the ack handshake or the last read word.
  assign w_done     = w_out_fire & ((r_state == S_WACK) | ((r_state == S_READ) & w_last));

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk_logic) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode from handshakes on either channel.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_in_fire) w_next = glip.fifo_in_data[15] ? S_WRITE : S_READ;
      S_WRITE: if (w_in_fire && w_last) w_next = S_WACK;
      S_WACK:  if (w_out_fire) w_next = S_IDLE;
      S_READ:  if (w_out_fire && w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs depend on state only, so no valid->ready feedthrough exists.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_data  = '0;
    case (r_state)
      S_IDLE:  w_in_ready = 1'b1;
      S_WRITE: w_in_ready = 1'b1;
      S_WACK: begin
        w_out_valid      = 1'b1;
        w_out_data[15:0] = r_hdr;
      end
      S_READ: begin
        w_out_valid = 1'b1;
        w_out_data  = r_mem[r_addr];
      end
      default: ;
    endcase
    // Nothing is accepted while reset is held.
    if (rst) begin
      w_in_ready = 1'b0;
    end
  end

  // Address/count/header and memory; data path carries no reset so the
  // memory keeps its contents across a reset.
  always_ff @(posedge clk_logic) begin
    case (r_state)
      S_IDLE: begin
        if (w_in_fire) begin
          r_addr <= glip.fifo_in_data[7:0];
          r_cnt  <= glip.fifo_in_data[14:8];
          r_hdr  <= glip.fifo_in_data[15:0];
        end
      end
      S_WRITE: begin
        if (w_in_fire) begin
          r_mem[r_addr] <= glip.fifo_in_data;
          r_addr        <= r_addr + 8'd1;
          r_cnt         <= r_cnt - 7'd1;
        end
      end
      S_READ: begin
        if (w_out_fire) begin
          r_addr <= r_addr + 8'd1;
          r_cnt  <= r_cnt - 7'd1;
        end
      end
      default: ;
    endcase
  end

  // Completed-transaction counter, wraps naturally at 16 bits.
  always_ff @(posedge clk_logic) begin
    if (rst) begin
      r_req_count <= 16'd0;
    end else if (w_done) begin
      r_req_count <= r_req_count + 16'd1;
    end
  end

  assign glip.fifo_in_ready  = w_in_ready;
  assign glip.fifo_out_valid = w_out_valid;
  assign glip.fifo_out_data  = w_out_data;
  assign busy                = (r_state != S_IDLE);
  assign req_count           = r_req_count;

endmodule
